// File: rtl/iob_sync_fifo_2p_pkg.sv
// Shared definitions for the IOb synchronous two-port FIFO.
//  - Default geometry and almost-flag thresholds. The default AFULL is 3/4 of DEPTH and the
//    default AEMPTY is 1/4 of DEPTH.
//  - The width of the level counter, which must hold 0..DEPTH inclusive.
//  - A packed flag structure. Its bit order fixes the bit positions of a future status register.
//    Bit 0 is full and bit 5 is underflow.
package iob_sync_fifo_2p_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // The level must represent DEPTH itself, so it is one bit wider than an address.
    function automatic int level_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int def_afull(input int addr_w);
        return (1 << addr_w) - ((1 << addr_w) / 4);
    endfunction

    function automatic int def_aempty(input int addr_w);
        return (1 << addr_w) / 4;
    endfunction

    // Status flags. The first field listed is the MSB.
    typedef struct packed {
        logic underflow;     // bit 5
        logic overflow;      // bit 4
        logic almost_empty;  // bit 3
        logic empty;         // bit 2
        logic almost_full;   // bit 1
        logic full;          // bit 0
    } fifo_flags_t;

endpackage

// File: rtl/iob_sync_fifo_2p_if.sv
// Producer/consumer bundle for iob_sync_fifo_2p.
//  master : the user side. It drives w_en, w_data and r_en, and observes data, flags and level.
//  slave  : the FIFO side.
//  Signals:
//   w_en, w_data                 : write request and data
//   w_full, w_almost_full        : write-side flags
//   w_overflow                   : write-side error pulse
//   r_en                         : read request
//   r_data                       : registered read data
//   r_empty, r_almost_empty      : read-side flags
//   r_underflow                  : read-side error pulse
//   level                        : occupancy 0..DEPTH
interface iob_sync_fifo_2p_if
    import iob_sync_fifo_2p_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic                          w_en;
    logic [DATA_W-1:0]             w_data;
    logic                          w_full;
    logic                          w_almost_full;
    logic                          w_overflow;
    logic                          r_en;
    logic [DATA_W-1:0]             r_data;
    logic                          r_empty;
    logic                          r_almost_empty;
    logic                          r_underflow;
    logic [level_w(ADDR_W)-1:0]    level;

    modport master (
        output w_en, w_data, r_en,
        input  w_full, w_almost_full, w_overflow,
        input  r_data, r_empty, r_almost_empty, r_underflow, level
    );

    modport slave (
        input  w_en, w_data, r_en,
        output w_full, w_almost_full, w_overflow,
        output r_data, r_empty, r_almost_empty, r_underflow, level
    );

endinterface

// File: rtl/iob_2p_ram.sv
// Two-port RAM for the IOb FIFO: one write port and one read port, both on clk.
// The read port is registered (latency 1), so block RAM can be inferred.
// Ports:
//   clk    : clock
//   rst    : synchronous reset, active-high; clears only the read output register
//   w_en   : write enable
//   w_addr : write address
//   w_data : write data
//   r_en   : read enable
//   r_addr : read address
//   r_data : registered read data; it holds its value while r_en is low
module iob_2p_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // The storage array has no reset, which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/iob_sync_fifo_2p.sv
// Synchronous single-clock FIFO built on iob_2p_ram.
// It provides:
//  - write and read pointers;
//  - an occupancy (level) counter;
//  - registered full/empty and almost flags, all derived from the level;
//  - one-cycle overflow and underflow pulses.
// Full and empty come from the level, never from pointer comparison.
// Ports:
//   clk : clock
//   rst : synchronous reset, active-high
//   bus : iob_sync_fifo_2p_if slave modport (write/read handshakes, data, flags, level)
module iob_sync_fifo_2p
    import iob_sync_fifo_2p_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int AFULL_LVL  = def_afull(ADDR_W),
    parameter int AEMPTY_LVL = def_aempty(ADDR_W)
) (
    input  logic               clk,
    input  logic               rst,
    iob_sync_fifo_2p_if.slave  bus
);

    localparam int LVL_W = level_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_LVL);
    localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_LVL);

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    fifo_flags_t       flags_reg;
    fifo_flags_t       flags_next;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance uses the registered flags.
    //  - At level 0, a simultaneous read is refused, so the new word never falls through.
    //  - At DEPTH, a simultaneous write is refused, while the read still frees a slot.
    always_comb begin
        wr_acc = bus.w_en & ~flags_reg.full;
        rd_acc = bus.r_en & ~flags_reg.empty;
    end

    always_comb begin
        level_next = level_reg;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // The flags are computed from the next level.
    // Each registered flag therefore lines up with the registered level in the same cycle.
    always_comb begin
        flags_next              = '0;
        flags_next.full         = (level_next == DEPTH_L);
        flags_next.almost_full  = (level_next >= AFULL_L);
        flags_next.empty        = (level_next == '0);
        flags_next.almost_empty = (level_next <= AEMPTY_L);
        flags_next.overflow     = bus.w_en & flags_reg.full;
        flags_next.underflow    = bus.r_en & flags_reg.empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg               <= '0;
            rptr_reg               <= '0;
            level_reg              <= '0;
            flags_reg              <= '0;
            flags_reg.empty        <= 1'b1;
            flags_reg.almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wptr_reg <= wptr_reg + ADDR_W'(1);
            end
            if (rd_acc) begin
                rptr_reg <= rptr_reg + ADDR_W'(1);
            end
            level_reg <= level_next;
            flags_reg <= flags_next;
        end
    end

    // The RAM output register is r_data itself.
    // Its reset is what makes r_data read 0 the cycle after rst.
    iob_2p_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .w_en   (wr_acc),
        .w_addr (wptr_reg),
        .w_data (bus.w_data),
        .r_en   (rd_acc),
        .r_addr (rptr_reg),
        .r_data (bus.r_data)
    );

    assign bus.w_full         = flags_reg.full;
    assign bus.w_almost_full  = flags_reg.almost_full;
    assign bus.w_overflow     = flags_reg.overflow;
    assign bus.r_empty        = flags_reg.empty;
    assign bus.r_almost_empty = flags_reg.almost_empty;
    assign bus.r_underflow    = flags_reg.underflow;
    assign bus.level          = level_reg;

endmodule

// File: tb/tb_iob_sync_fifo_2p.sv
// Self-checking bench for iob_sync_fifo_2p (DATA_W=8, ADDR_W=4, AFULL=12, AEMPTY=4).
// Stimulus pushes the expected word for every read it expects to be accepted.
// A separate monitor pops and compares r_data one step after each accepting edge.
module tb_iob_sync_fifo_2p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    iob_sync_fifo_2p_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    iob_sync_fifo_2p #(
        .DATA_W     (8),
        .ADDR_W     (4),
        .AFULL_LVL  (12),
        .AEMPTY_LVL (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus.
    // Inputs are applied at the falling edge and released 2 time units after the rising edge.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                       input logic push, input logic [7:0] rd);
        @(negedge clk);
        bus.w_en   = we;
        bus.w_data = wd;
        bus.r_en   = re;
        if (push) exp_q.push_back(rd);
        @(posedge clk);
        #2;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        $display("txn w_en=%0b w_data=%0d r_en=%0b -> level=%0d r_data=%0d full=%0b empty=%0b ovf=%0b udf=%0b",
                 we, wd, re, bus.level, bus.r_data, bus.w_full, bus.r_empty,
                 bus.w_overflow, bus.r_underflow);
    endtask

    // Monitor: a read presented while not empty and not in reset is accepted.
    // Its word appears on r_data right after that edge.
    initial begin
        logic fire;
        forever begin
            @(posedge clk);
            fire = bus.r_en && !bus.r_empty && !rst;
            #1;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got r_data=%0d, expected no read", bus.r_data);
                end else begin
                    chk("rd_data", 32'(bus.r_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.w_en   = 1'b0;
        bus.w_data = '0;
        bus.r_en   = 1'b0;

        // 1: reset, then 3 idle cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("rst_level",  32'(bus.level), 0);
        chk("rst_empty",  32'(bus.r_empty), 1);
        chk("rst_aempty", 32'(bus.r_almost_empty), 1);
        chk("rst_full",   32'(bus.w_full), 0);
        chk("rst_afull",  32'(bus.w_almost_full), 0);
        chk("rst_rdata",  32'(bus.r_data), 0);
        chk("rst_ovf",    32'(bus.w_overflow), 0);
        chk("rst_udf",    32'(bus.r_underflow), 0);

        // 2: fill with 32..47, then attempt a 17th write
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(32 + i), 0, 0, 0);
            chk("fill_level", 32'(bus.level), 32'(i + 1));
            chk("fill_afull", 32'(bus.w_almost_full), 32'(i + 1 >= 12));
            chk("fill_full",  32'(bus.w_full), 32'(i == 15));
            chk("fill_empty", 32'(bus.r_empty), 0);
        end
        cyc(1, 99, 0, 0, 0);
        chk("ovf_pulse", 32'(bus.w_overflow), 1);
        chk("ovf_level", 32'(bus.level), 16);
        cyc(0, 0, 0, 0, 0);
        chk("ovf_clear", 32'(bus.w_overflow), 0);

        // 3: drain, then attempt an extra read
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 1, 8'(32 + i));
            chk("drain_level",  32'(bus.level), 32'(15 - i));
            chk("drain_aempty", 32'(bus.r_almost_empty), 32'(15 - i <= 4));
        end
        chk("drain_empty", 32'(bus.r_empty), 1);
        cyc(0, 0, 1, 0, 0);
        chk("udf_pulse", 32'(bus.r_underflow), 1);
        chk("udf_hold",  32'(bus.r_data), 47);
        cyc(0, 0, 0, 0, 0);
        chk("udf_clear", 32'(bus.r_underflow), 0);

        // 4: pointer wrap
        for (int i = 0; i < 10; i++) cyc(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 8'(i));
        for (int i = 0; i < 16; i++) cyc(1, 8'(64 + i), 0, 0, 0);
        chk("wrap_full", 32'(bus.w_full), 1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 1, 8'(64 + i));
        chk("wrap_level", 32'(bus.level), 0);
        chk("wrap_empty", 32'(bus.r_empty), 1);

        // 5a: simultaneous requests at level 5
        for (int i = 0; i < 5; i++) cyc(1, 8'(100 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'(105 + i), 1, 1, 8'(100 + i));
            chk("sim5_level", 32'(bus.level), 5);
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 8'(103 + i));
        chk("sim5_drained", 32'(bus.level), 0);

        // 5b: simultaneous requests at level 0 (the read is refused)
        cyc(1, 120, 1, 0, 0);
        chk("sim0_udf",   32'(bus.r_underflow), 1);
        chk("sim0_level", 32'(bus.level), 1);

        // 5c: simultaneous requests at level 16 (the write is refused)
        for (int i = 0; i < 15; i++) cyc(1, 8'(121 + i), 0, 0, 0);
        chk("sim16_full", 32'(bus.w_full), 1);
        cyc(1, 200, 1, 1, 120);
        chk("sim16_ovf",   32'(bus.w_overflow), 1);
        chk("sim16_level", 32'(bus.level), 15);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 1, 8'(121 + i));
        chk("sim16_drained", 32'(bus.level), 0);

        // 6: reset at level 7 while both requests are high
        for (int i = 0; i < 7; i++) cyc(1, 8'(1 + i), 0, 0, 0);
        chk("pre_rst_level", 32'(bus.level), 7);
        @(negedge clk);
        rst        = 1'b1;
        bus.w_en   = 1'b1;
        bus.w_data = 8'hEE;
        bus.r_en   = 1'b1;
        @(posedge clk);
        #2;
        rst      = 1'b0;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        $display("txn rst=1 w_en=1 r_en=1 -> level=%0d r_data=%0d", bus.level, bus.r_data);
        chk("mrst_level", 32'(bus.level), 0);
        chk("mrst_empty", 32'(bus.r_empty), 1);
        chk("mrst_rdata", 32'(bus.r_data), 0);
        chk("mrst_ovf",   32'(bus.w_overflow), 0);
        chk("mrst_udf",   32'(bus.r_underflow), 0);
        cyc(1, 8'h5A, 0, 0, 0);
        chk("post_rst_level", 32'(bus.level), 1);
        cyc(0, 0, 1, 1, 8'h5A);
        chk("post_rst_empty", 32'(bus.r_empty), 1);

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
